fb_scanout: RTL

//  Framebuffer scan-out stage between dp_ram read port B and the VGA timing logic.

---
 rtl/fb_scanout.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer scan-out stage.
// Prefetches 32-bit framebuffer words from dp_ram port B into a small FIFO and
// hands them to the VGA timing logic one RGB332 byte per qualified pixel request.
// The read pipeline is two stages deep: the address sits on addr_r for one cycle
// (rd_vld_q), then the RAM data sits on din for one cycle (din_vld_q) and is
// written into the FIFO at the end of that cycle.
module fb_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [ADDR_W-1:0] addr_r,
    input  logic [31:0]       din,
    output logic [7:0]        rgb,
    output logic              underrun,
    output logic              frame_done
);

    localparam int WORDS = (H_ACTIVE * V_ACTIVE) / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [OCC_W-1:0]  DEPTH_C  = OCC_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] addr_r_q,     addr_r_d;
    logic [IDX_W-1:0]  word_idx_q,   word_idx_d;
    logic              rd_vld_q,     rd_vld_d;
    logic              din_vld_q,    din_vld_d;
    logic [1:0]        byte_sel_q,   byte_sel_d;
    logic [7:0]        rgb_q,        rgb_d;
    logic              underrun_q,   underrun_d;
    logic              frame_done_q, frame_done_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [31:0]       fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [CNT_W-1:0]  count_q,      count_d;

    logic [1:0]        in_flight_s;
    logic [OCC_W-1:0]  occupancy_s;
    logic              fifo_empty_s;
    logic [31:0]       head_word_s;
    logic [7:0]        head_byte_s;
    logic              push_s;
    logic              pop_s;

    // Reads still travelling through the RAM pipeline count against FIFO space,
    // so a word is only requested when a slot is guaranteed on arrival.
    always_comb begin
        in_flight_s  = {1'b0, rd_vld_q} + {1'b0, din_vld_q};
        occupancy_s  = OCC_W'(count_q) + OCC_W'(in_flight_s);
        fifo_empty_s = (count_q == CNT_W'(0));
    end

    // Select the current byte of the FIFO head word, lowest byte first.
    always_comb begin
        head_word_s = fifo_mem_q[rd_ptr_q];
        case (byte_sel_q)
            2'd0:    head_byte_s = head_word_s[7:0];
            2'd1:    head_byte_s = head_word_s[15:8];
            2'd2:    head_byte_s = head_word_s[23:16];
            2'd3:    head_byte_s = head_word_s[31:24];
            default: head_byte_s = 8'd0;
        endcase
    end

    // Next-state logic: fetch FSM, read pipeline, pixel unpacking and FIFO pointers.
    always_comb begin
        state_d      = state_q;
        addr_r_d     = addr_r_q;
        word_idx_d   = word_idx_q;
        rd_vld_d     = rd_vld_q;
        din_vld_d    = din_vld_q;
        byte_sel_d   = byte_sel_q;
        rgb_d        = rgb_q;
        underrun_d   = underrun_q;
        frame_done_d = 1'b0;
        fifo_mem_d   = fifo_mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        push_s       = 1'b0;
        pop_s        = 1'b0;

        if (frame_start) begin
            // Restart: flush FIFO, drop anything in the RAM pipeline, ignore any pop.
            state_d    = S_FETCH;
            word_idx_d = '0;
            rd_vld_d   = 1'b0;
            din_vld_d  = 1'b0;
            byte_sel_d = 2'd0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            push_s    = din_vld_q;
            din_vld_d = rd_vld_q;
            rd_vld_d  = 1'b0;

            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_FETCH: begin
                    if (occupancy_s < DEPTH_C) begin
                        addr_r_d   = BASE + ADDR_W'(word_idx_q);
                        rd_vld_d   = 1'b1;
                        word_idx_d = word_idx_q + IDX_W'(1);
                        if (word_idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_DONE: begin
                    // Address stage empty means the last word is on din and lands now.
                    if (!rd_vld_q) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (pix_en) begin
                if (pix_req) begin
                    if (fifo_empty_s) begin
                        rgb_d      = 8'd0;
                        underrun_d = 1'b1;
                    end else begin
                        rgb_d      = head_byte_s;
                        byte_sel_d = byte_sel_q + 2'd1;
                        pop_s      = (byte_sel_q == 2'd3);
                    end
                end else begin
                    rgb_d = 8'd0;
                end
            end else begin
                rgb_d = rgb_q;
            end

            if (push_s) begin
                fifo_mem_d[wr_ptr_q] = din;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset taking priority over all.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_r_q     <= BASE;
            word_idx_q   <= '0;
            rd_vld_q     <= 1'b0;
            din_vld_q    <= 1'b0;
            byte_sel_q   <= 2'd0;
            rgb_q        <= 8'd0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
            fifo_mem_q   <= '{default: 32'd0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_r_q     <= addr_r_d;
            word_idx_q   <= word_idx_d;
            rd_vld_q     <= rd_vld_d;
            din_vld_q    <= din_vld_d;
            byte_sel_q   <= byte_sel_d;
            rgb_q        <= rgb_d;
            underrun_q   <= underrun_d;
            frame_done_q <= frame_done_d;
            fifo_mem_q   <= fifo_mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    assign addr_r     = addr_r_q;
    assign rgb        = rgb_q;
    assign underrun   = underrun_q;
    assign frame_done = frame_done_q;

endmodule
